// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the decode stage.
// Evaluates BEQZ/BNEZ/BLTZ/BGEZ against Rs. Stalls decode until Rs is ready.
// Computes pc_plus2 + imm_sext. A taken branch flushes IF/ID and holds a PC
// redirect until fetch accepts it.
// Optional feature macro: BRANCH_STATS_EN (saturating branch/taken counters).
module branch_resolve_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             branch,
    input  logic [4:0]       opcode,
    input  logic [DW-1:0]    rs_data,
    input  logic             rs_ready,
    input  logic [DW-1:0]    pc_plus2,
    input  logic [DW-1:0]    imm_sext,
    input  logic             kill,
    input  logic             fetch_ack,
    output logic             stall_id,
    output logic             flush_ifid,
    output logic             redirect_valid,
    output logic [DW-1:0]    redirect_pc,
    output logic             resolved,
    output logic             taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_OP  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;       // low opcode bits select the condition
    logic [DW-1:0] tgt_q, tgt_d;     // target latched while waiting for Rs
    logic          flush_q, flush_d;
    logic          rv_q, rv_d;
    logic [DW-1:0] rpc_q, rpc_d;
    logic          res_q, res_d;
    logic          tkn_q, tkn_d;

    logic          legal_op;
    logic          accept;
    logic [1:0]    cur_op;
    logic [DW-1:0] cur_tgt;
    logic          cond_true;
    logic          resolve_now;
    logic          take_now;

    // Decode, condition evaluation and resolve qualification
    always_comb begin
        legal_op = (opcode[4:2] == 3'b011);
        accept   = (state_q == ST_IDLE) & id_valid & branch & legal_op & ~kill;

        // In IDLE the live decode inputs apply; in WAIT_OP the latched ones do.
        if (state_q == ST_WAIT_OP) begin
            cur_op  = op_q;
            cur_tgt = tgt_q;
        end else begin
            cur_op  = opcode[1:0];
            cur_tgt = pc_plus2 + imm_sext;
        end

        unique case (cur_op)
            2'b00:   cond_true = (rs_data == '0);
            2'b01:   cond_true = (rs_data != '0);
            2'b10:   cond_true = rs_data[DW-1];
            default: cond_true = ~rs_data[DW-1];
        endcase

        resolve_now = ~kill & rs_ready & (accept | (state_q == ST_WAIT_OP));
        take_now    = resolve_now & cond_true;
    end

    // Next-state logic for the FSM, latches and registered outputs
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        rv_d    = rv_q;
        rpc_d   = rpc_q;
        res_d   = resolve_now;
        tkn_d   = take_now;
        flush_d = take_now;

        if (kill) begin
            state_d = ST_IDLE;
            rv_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && !rs_ready) begin
                        state_d = ST_WAIT_OP;
                        op_d    = opcode[1:0];
                        tgt_d   = cur_tgt;
                    end else if (take_now) begin
                        state_d = ST_REDIRECT;
                    end
                end
                ST_WAIT_OP: begin
                    if (rs_ready) begin
                        state_d = take_now ? ST_REDIRECT : ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_ack) begin
                        state_d = ST_IDLE;
                        rv_d    = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_now) begin
                rv_d  = 1'b1;
                rpc_d = cur_tgt;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            res_q   <= 1'b0;
            tkn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            res_q   <= res_d;
            tkn_q   <= tkn_d;
        end
    end

    // Decode stall: waiting on Rs, or redirect not yet accepted by fetch
    always_comb begin
        stall_id = (accept & ~rs_ready)
                 | (state_q == ST_WAIT_OP)
                 | ((state_q == ST_REDIRECT) & ~fetch_ack);
    end

    assign flush_ifid     = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign resolved       = res_q;
    assign taken          = tkn_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Saturating counters, stepped at the edge that raises the resolved pulse
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (resolve_now && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (take_now && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`else
    assign br_cnt    = '0;
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
// With BRANCH_STATS_EN defined the DUT is built with 2-bit counters.
module tb_branch_resolve_ctrl;

    localparam int unsigned DW = 16;
`ifdef BRANCH_STATS_EN
    localparam int unsigned CNT_W   = 2;
    localparam logic [31:0] EXP_BR  = 32'd3;
    localparam logic [31:0] EXP_TKN = 32'd3;
`else
    localparam int unsigned CNT_W   = 16;
    localparam logic [31:0] EXP_BR  = 32'd0;
    localparam logic [31:0] EXP_TKN = 32'd0;
`endif

    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, branch, rs_ready, kill, fetch_ack;
    logic [4:0]       opcode;
    logic [DW-1:0]    rs_data, pc_plus2, imm_sext;
    logic             stall_id, flush_ifid, redirect_valid, resolved, taken;
    logic [DW-1:0]    redirect_pc;
    logic [CNT_W-1:0] br_cnt, taken_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .branch         (branch),
        .opcode         (opcode),
        .rs_data        (rs_data),
        .rs_ready       (rs_ready),
        .pc_plus2       (pc_plus2),
        .imm_sext       (imm_sext),
        .kill           (kill),
        .fetch_ack      (fetch_ack),
        .stall_id       (stall_id),
        .flush_ifid     (flush_ifid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resolved       (resolved),
        .taken          (taken),
        .br_cnt         (br_cnt),
        .taken_cnt      (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        branch    = 1'b0;
        opcode    = 5'd0;
        rs_ready  = 1'b0;
        kill      = 1'b0;
        fetch_ack = 1'b0;
    endtask

    task automatic drive_br(input logic [4:0] op, input logic [DW-1:0] rs, input logic rdy,
                            input logic [DW-1:0] pc, input logic [DW-1:0] imm);
        id_valid = 1'b1;
        branch   = 1'b1;
        opcode   = op;
        rs_data  = rs;
        rs_ready = rdy;
        pc_plus2 = pc;
        imm_sext = imm;
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic res, input logic tkn,
                                input logic fl, input logic rv);
        check({tag, "_resolved"}, 32'(resolved), 32'(res));
        check({tag, "_taken"}, 32'(taken), 32'(tkn));
        check({tag, "_flush"}, 32'(flush_ifid), 32'(fl));
        check({tag, "_rvalid"}, 32'(redirect_valid), 32'(rv));
    endtask

    initial begin
        rst_n = 1'b0;
        rs_data = '0; pc_plus2 = '0; imm_sext = '0;
        idle_inputs();
        #12;
        check_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_rpc", 32'(redirect_pc), 32'h0);
        check("reset_stall", 32'(stall_id), 32'h0);
        check("reset_brcnt", 32'(br_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: BEQZ taken, redirect held until fetch_ack
        drive_br(OP_BEQZ, 16'h0000, 1'b1, 16'h0010, 16'h0006);
        check("t1_stall_pre", 32'(stall_id), 32'h0);
        tick();
        idle_inputs();
        check_pulses("t1", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t1_rpc", 32'(redirect_pc), 32'h0016);
        check("t1_stall", 32'(stall_id), 32'h1);
        tick();
        check_pulses("t1_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_rpc_hold", 32'(redirect_pc), 32'h0016);
        fetch_ack = 1'b1;
        #1;
        check("t1_stall_ack", 32'(stall_id), 32'h0);
        tick();
        fetch_ack = 1'b0;
        check("t1_rv_off", 32'(redirect_valid), 32'h0);

        // 2: BNEZ with rs=0 is not taken
        drive_br(OP_BNEZ, 16'h0000, 1'b1, 16'h0030, 16'h0010);
        check("t2_stall_pre", 32'(stall_id), 32'h0);
        tick();
        idle_inputs();
        check_pulses("t2", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_stall", 32'(stall_id), 32'h0);
        tick();
        check("t2_res_off", 32'(resolved), 32'h0);

        // 3: BLTZ waits 3 cycles for Rs; target comes from latched pc/imm
        drive_br(OP_BLTZ, 16'h0000, 1'b0, 16'h0100, 16'h0020);
        check("t3_stall_c1", 32'(stall_id), 32'h1);
        tick();
        id_valid = 1'b0; branch = 1'b0; opcode = 5'd0;
        pc_plus2 = 16'h0500; imm_sext = 16'h0001; rs_data = 16'h8000;
        #1;
        check("t3_stall_c2", 32'(stall_id), 32'h1);
        check("t3_res_wait", 32'(resolved), 32'h0);
        tick();
        check("t3_stall_c3", 32'(stall_id), 32'h1);
        tick();
        rs_ready = 1'b1;
        #1;
        check("t3_stall_resolve", 32'(stall_id), 32'h1);
        tick();
        idle_inputs();
        check_pulses("t3", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t3_rpc", 32'(redirect_pc), 32'h0120);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check("t3_rv_off", 32'(redirect_valid), 32'h0);

        // 4: BGEZ target wraps; fetch_ack delayed 4 cycles
        drive_br(OP_BGEZ, 16'h7FFF, 1'b1, 16'hFFFE, 16'h0004);
        tick();
        idle_inputs();
        check_pulses("t4", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_rpc", 32'(redirect_pc), 32'h0002);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_rv_hold", 32'(redirect_valid), 32'h1);
            check("t4_rpc_hold", 32'(redirect_pc), 32'h0002);
            check("t4_stall_hold", 32'(stall_id), 32'h1);
        end
        // A new branch in decode during REDIRECT is ignored
        drive_br(OP_BEQZ, 16'h0000, 1'b1, 16'h0200, 16'h0002);
        tick();
        idle_inputs();
        check("t4_ignore_res", 32'(resolved), 32'h0);
        check("t4_ignore_rpc", 32'(redirect_pc), 32'h0002);
        fetch_ack = 1'b1;
        #1;
        check("t4_stall_ack", 32'(stall_id), 32'h0);
        tick();
        fetch_ack = 1'b0;
        check("t4_rv_off", 32'(redirect_valid), 32'h0);

        // 5a: kill during WAIT_OP
        drive_br(OP_BEQZ, 16'h0000, 1'b0, 16'h0040, 16'h0002);
        tick();
        idle_inputs();
        kill = 1'b1; rs_ready = 1'b1; rs_data = 16'h0000;
        tick();
        idle_inputs();
        check_pulses("t5a", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5a_stall", 32'(stall_id), 32'h0);

        // 5b: kill during REDIRECT
        drive_br(OP_BEQZ, 16'h0000, 1'b1, 16'h0020, 16'h0002);
        tick();
        idle_inputs();
        check("t5b_rv_on", 32'(redirect_valid), 32'h1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        check_pulses("t5b", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5b_stall", 32'(stall_id), 32'h0);

        // 5c: kill in IDLE blocks accept
        drive_br(OP_BEQZ, 16'h0000, 1'b0, 16'h0060, 16'h0002);
        kill = 1'b1;
        #1;
        check("t5c_stall", 32'(stall_id), 32'h0);
        tick();
        idle_inputs();
        check("t5c_stall_after", 32'(stall_id), 32'h0);
        check("t5c_res", 32'(resolved), 32'h0);

        // 6: illegal opcode with branch=1 has no effect
        drive_br(5'b00000, 16'h0000, 1'b0, 16'h0070, 16'h0002);
        check("t6_stall", 32'(stall_id), 32'h0);
        tick();
        idle_inputs();
        check("t6_res", 32'(resolved), 32'h0);
        check("t6_stall_after", 32'(stall_id), 32'h0);

        // One more taken branch: 6 resolved, 5 taken in total
        drive_br(OP_BEQZ, 16'h0000, 1'b1, 16'h0080, 16'h0002);
        tick();
        idle_inputs();
        check("t7_rpc", 32'(redirect_pc), 32'h0082);
        check("cnt_br", 32'(br_cnt), EXP_BR);
        check("cnt_taken", 32'(taken_cnt), EXP_TKN);

        // Async reset mid-REDIRECT clears outputs immediately
        #3;
        rst_n = 1'b0;
        #1;
        check_pulses("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_rpc", 32'(redirect_pc), 32'h0);
        check("rst_mid_stall", 32'(stall_id), 32'h0);
        check("rst_mid_brcnt", 32'(br_cnt), 32'h0);
        check("rst_mid_tkncnt", 32'(taken_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
